// File: rtl/qacc_pipe.sv
// Multi-lane fixed-point add/sub/accumulate pipeline with a single registered
// result stage; overflow is saturated or wrapped per lane.
module qacc_pipe #(
    parameter int unsigned N     = 8,
    parameter int unsigned Q     = 4,
    parameter int unsigned LANES = 4,
    parameter int unsigned SAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic                 last,
    input  logic [LANES*N-1:0]   a,
    input  logic [LANES*N-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   c,
    output logic [LANES-1:0]     ovf
);

    localparam int unsigned W  = LANES * N;
    localparam int unsigned NW = N + 1;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;

    // Q only labels the fixed-point format; it must still leave room for the sign bit.
    if (Q >= N) begin : g_q_check
        $error("qacc_pipe: Q must be less than N");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           xfer_c;
    logic           emit_c;
    logic           acc_we_c;
    logic [W-1:0]   acc;
    logic [LANES-1:0] acc_ovf;
    logic [W-1:0]   res_c;
    logic [LANES-1:0] res_ovf_c;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign xfer_c   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer_c && (mode == MODE_ACC) && !last) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer_c && last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat decode: which transfers update the accumulator and which emit a result
    always_comb begin
        emit_c   = 1'b0;
        acc_we_c = 1'b0;
        case (state)
            IDLE: begin
                if (xfer_c) begin
                    if (mode == MODE_ACC) begin
                        acc_we_c = 1'b1;
                        emit_c   = last;
                    end else begin
                        emit_c   = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (xfer_c) begin
                    acc_we_c = 1'b1;
                    emit_c   = last;
                end
            end
            default: begin
                emit_c   = 1'b0;
                acc_we_c = 1'b0;
            end
        endcase
    end

    // Per-lane N+1-bit arithmetic, overflow detection and clamp/wrap
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [N-1:0]  a_l;
        logic [N-1:0]  b_l;
        logic [N-1:0]  acc_l;
        logic [NW-1:0] lhs;
        logic [NW-1:0] rhs;
        logic [NW-1:0] sum;
        logic          ov;
        logic [N-1:0]  res_l;

        assign a_l   = a[i*N +: N];
        assign b_l   = b[i*N +: N];
        assign acc_l = acc[i*N +: N];

        always_comb begin
            lhs = {a_l[N-1], a_l};
            rhs = {b_l[N-1], b_l};
            if (state == ACCUM) begin
                lhs = {acc_l[N-1], acc_l};
                rhs = {a_l[N-1], a_l};
            end else if (mode == MODE_ACC) begin
                rhs = '0;
            end else if (mode == MODE_SUB) begin
                rhs = NW'(0) - {b_l[N-1], b_l};
            end
        end

        assign sum = lhs + rhs;
        assign ov  = sum[N] ^ sum[N-1];

        always_comb begin
            res_l = sum[N-1:0];
            if (ov && (SAT != 0)) begin
                res_l = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            end
        end

        assign res_c[i*N +: N] = res_l;
        assign res_ovf_c[i]    = ov | ((state == ACCUM) & acc_ovf[i]);
    end

    // Accumulator and sticky overflow; a last beat ends the sequence and clears both
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            acc_ovf <= '0;
        end else if (acc_we_c) begin
            if (last) begin
                acc     <= '0;
                acc_ovf <= '0;
            end else begin
                acc     <= res_c;
                acc_ovf <= res_ovf_c;
            end
        end
    end

    // Single output register; a new result may load while the old one drains
    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= '0;
            ovf       <= '0;
            out_valid <= 1'b0;
        end else if (emit_c) begin
            c         <= res_c;
            ovf       <= res_ovf_c;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qacc_pipe.sv
// Scoreboard bench for qacc_pipe: a behavioural lane model predicts each
// emitted result; a wrap-mode instance shares the stimulus for SAT=0 cases.
module tb_qacc_pipe;

    localparam int N     = 8;
    localparam int LANES = 4;
    localparam int W     = N * LANES;

    typedef struct {
        logic [W-1:0]     c;
        logic [LANES-1:0] ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [1:0]       mode;
    logic             last;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_ready;
    logic             in_ready, in_ready_w;
    logic             out_valid, out_valid_w;
    logic [W-1:0]     c, c_w;
    logic [LANES-1:0] ovf, ovf_w;

    exp_t             q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [N-1:0]     m_acc[LANES];
    logic [LANES-1:0] m_ovf;
    bit               m_accum;

    always #5 clk = ~clk;

    qacc_pipe #(.N(8), .Q(4), .LANES(4), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .last(last), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf)
    );

    qacc_pipe #(.N(8), .Q(4), .LANES(4), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .mode(mode), .last(last), .a(a), .b(b),
        .out_valid(out_valid_w), .out_ready(out_ready), .c(c_w), .ovf(ovf_w)
    );

    function automatic int sx(input logic [N-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic void lane_eval(input int r, output logic [N-1:0] res, output bit ov);
        ov = (r > 127) || (r < -128);
        if (ov) res = (r > 127) ? 8'h7F : 8'h80;
        else    res = 8'(r);
    endfunction

    function automatic logic [W-1:0] word(input logic [N-1:0] lane0);
        return {24'($urandom), lane0};
    endfunction

    // Behavioural model of one accepted beat (saturating); pushes any emitted result
    task automatic model_step(input logic [1:0] md, input logic lst,
                              input logic [W-1:0] aa, input logic [W-1:0] bb,
                              output bit prod);
        exp_t         e;
        int           r;
        logic [N-1:0] res;
        bit           ov;
        prod  = 0;
        e.c   = '0;
        e.ovf = '0;
        if (!m_accum && md == 2'b10) begin
            m_ovf = '0;
            for (int i = 0; i < LANES; i++) m_acc[i] = aa[i*N +: N];
            if (lst) begin
                e.c = aa;
                q.push_back(e);
                prod = 1;
                for (int i = 0; i < LANES; i++) m_acc[i] = '0;
            end else begin
                m_accum = 1;
            end
        end else if (m_accum) begin
            for (int i = 0; i < LANES; i++) begin
                r = sx(m_acc[i]) + sx(aa[i*N +: N]);
                lane_eval(r, res, ov);
                m_acc[i] = res;
                if (ov) m_ovf[i] = 1'b1;
            end
            if (lst) begin
                for (int i = 0; i < LANES; i++) begin
                    e.c[i*N +: N] = m_acc[i];
                    m_acc[i] = '0;
                end
                e.ovf = m_ovf;
                q.push_back(e);
                prod    = 1;
                m_ovf   = '0;
                m_accum = 0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (md == 2'b01) r = sx(aa[i*N +: N]) - sx(bb[i*N +: N]);
                else             r = sx(aa[i*N +: N]) + sx(bb[i*N +: N]);
                lane_eval(r, res, ov);
                e.c[i*N +: N] = res;
                e.ovf[i]      = ov;
            end
            q.push_back(e);
            prod = 1;
        end
    endtask

    // Drive one beat for exactly one clock edge, then scramble the idle inputs
    task automatic beat(input logic [1:0] md, input logic lst,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output bit prod);
        model_step(md, lst, aa, bb, prod);
        mode = md; last = lst; a = aa; b = bb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode = 2'($urandom);
        last = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mode = 2'b00; last = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || c !== '0 || ovf !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b c=%h ovf=%b, expected 0/0/0", out_valid, c, ovf);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b, expected 0", in_ready);
        end
        rst = 1'b0;
        m_accum = 0; m_ovf = '0;
        for (int i = 0; i < LANES; i++) m_acc[i] = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_add_sub();
        logic [1:0]   md [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
        logic [N-1:0] la [6] = '{8'h18, 8'h70, 8'h80, 8'h00, 8'h7F, 8'h80};
        logic [N-1:0] lb [6] = '{8'h10, 8'h20, 8'h01, 8'h80, 8'h01, 8'hFF};
        exp_t e;
        bit   prod;
        for (int k = 0; k < 6; k++) begin
            beat(md[k], 1'($urandom), word(la[k]), word(lb[k]), prod);
            e = q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || c !== e.c || ovf !== e.ovf) begin
                failures++;
                $display("FAIL addsub_%0d: got valid=%b c=%h ovf=%b, expected valid=1 c=%h ovf=%b",
                         k, out_valid, c, ovf, e.c, e.ovf);
            end
            if (k == 0) begin
                checks++;
                if (c[7:0] !== 8'h28 || ovf[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL add_basic_lane0: got %h ovf=%b, expected 28 ovf=0", c[7:0], ovf[0]);
                end
            end
            if (k == 1) begin
                checks++;
                if (c[7:0] !== 8'h7F || ovf[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL add_sat_lane0: got %h ovf=%b, expected 7f ovf=1", c[7:0], ovf[0]);
                end
                checks++;
                if (out_valid_w !== 1'b1 || c_w[7:0] !== 8'h90 || ovf_w[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL add_wrap_lane0: got v=%b %h ovf=%b, expected v=1 90 ovf=1",
                             out_valid_w, c_w[7:0], ovf_w[0]);
                end
            end
            if (k == 2 || k == 3) begin
                checks++;
                if (c[7:0] !== ((k == 2) ? 8'h80 : 8'h7F) || ovf[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL sub_sat_lane0_%0d: got %h ovf=%b, expected %h ovf=1",
                             k, c[7:0], ovf[0], (k == 2) ? 8'h80 : 8'h7F);
                end
            end
        end
    endtask

    task automatic test_acc();
        logic [N-1:0] la [7] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h70, 8'h70, 8'hF0};
        logic         ll [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_t e;
        bit   prod;
        for (int k = 0; k < 7; k++) begin
            beat(2'b10, ll[k], word(la[k]), word(8'h00), prod);
            checks++;
            if (out_valid !== prod) begin
                failures++;
                $display("FAIL acc_valid_%0d: got %b, expected %b", k, out_valid, prod);
            end
            if (prod) begin
                e = q.pop_front();
                checks++;
                if (c !== e.c || ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL acc_result_%0d: got c=%h ovf=%b, expected c=%h ovf=%b",
                             k, c, ovf, e.c, e.ovf);
                end
                checks++;
                if (c[7:0] !== ((k == 3) ? 8'h40 : 8'h6F) || ovf[0] !== (k == 6)) begin
                    failures++;
                    $display("FAIL acc_lane0_%0d: got %h ovf=%b, expected %h ovf=%b",
                             k, c[7:0], ovf[0], (k == 3) ? 8'h40 : 8'h6F, (k == 6));
                end
            end
        end
        beat(2'b10, 1'b1, word(8'h05), word(8'h00), prod);
        e = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || c !== e.c || c[7:0] !== 8'h05 || ovf !== '0) begin
            failures++;
            $display("FAIL acc_single: got valid=%b c=%h ovf=%b, expected valid=1 c=%h ovf=0",
                     out_valid, c, ovf, e.c);
        end
    endtask

    task automatic test_backpressure();
        exp_t         e1, e2;
        bit           prod;
        logic [W-1:0] a2, b2;
        beat(2'b00, 1'b0, word(8'h21), word(8'h03), prod);
        e1 = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || c !== e1.c) begin
            failures++;
            $display("FAIL bp_first: got valid=%b c=%h, expected valid=1 c=%h", out_valid, c, e1.c);
        end
        a2 = word(8'h44); b2 = word(8'h11);
        out_ready = 1'b0; mode = 2'b01; last = 1'b0; a = a2; b = b2; in_valid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || c !== e1.c || ovf !== e1.ovf || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: got valid=%b c=%h ready=%b, expected valid=1 c=%h ready=0",
                         k, out_valid, c, in_ready, e1.c);
            end
            @(posedge clk);
            #1;
        end
        model_step(2'b01, 1'b0, a2, b2, prod);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e2 = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || c !== e2.c || ovf !== e2.ovf) begin
            failures++;
            $display("FAIL bp_drain_accept: got valid=%b c=%h ovf=%b, expected valid=1 c=%h ovf=%b",
                     out_valid, c, ovf, e2.c, e2.ovf);
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        bit         prod;
        logic [1:0] md;
        for (int k = 0; k < 8; k++) begin
            md = (k % 3 == 0) ? 2'b01 : ((k % 3 == 1) ? 2'b00 : 2'b11);
            beat(md, 1'b0, word(8'($urandom)), word(8'($urandom)), prod);
            e = q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || c !== e.c || ovf !== e.ovf) begin
                failures++;
                $display("FAIL b2b_%0d: got valid=%b c=%h ovf=%b, expected valid=1 c=%h ovf=%b",
                         k, out_valid, c, ovf, e.c, e.ovf);
            end
        end
        // Idle cycles with scrambled inputs must produce nothing
        for (int k = 0; k < 3; k++) begin
            a = word(8'($urandom)); mode = 2'b10; last = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_%0d: got valid=%b, expected 0", k, out_valid);
            end
        end
    endtask

    task automatic test_rst_abort();
        exp_t e;
        bit   prod;
        for (int k = 0; k < 2; k++) begin
            beat(2'b10, 1'b0, word(8'h11), word(8'h00), prod);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort_beat_%0d: got valid=%b, expected 0", k, out_valid);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_ready: got %b, expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_accum = 0; m_ovf = '0;
        for (int i = 0; i < LANES; i++) m_acc[i] = '0;
        checks++;
        if (out_valid !== 1'b0 || c !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got valid=%b c=%h, expected 0/0", out_valid, c);
        end
        beat(2'b10, 1'b1, word(8'h03), word(8'h00), prod);
        e = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || c !== e.c || c[7:0] !== 8'h03 || ovf !== '0) begin
            failures++;
            $display("FAIL abort_restart: got valid=%b c=%h ovf=%b, expected valid=1 c=%h ovf=0",
                     out_valid, c, ovf, e.c);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d pending, expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_acc();
        test_backpressure();
        test_back_to_back();
        test_rst_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qacc_pipe.md
QACC_PIPE -- requirements
Module: qacc_pipe

Interface
REQ-001 SHALL have parameter N, default 8, total word width in bits (two's complement, 1 sign bit).
REQ-002 SHALL have parameter Q, default 4, fractional bits; Q < N; Q carries no arithmetic effect other than format labelling.
REQ-003 SHALL have parameter LANES, default 4, number of independent parallel lanes.
REQ-004 SHALL have parameter SAT, default 1, where 1 = saturating and 0 = wrap-around arithmetic.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge triggered.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a beat; a beat transfers when in_valid && in_ready.
REQ-009 SHALL have port mode, input, 2 bits: 00 ADD, 01 SUB, 10 ACC, 11 reserved (treated as ADD).
REQ-010 SHALL have port last, input, 1 bit: final beat of an ACC sequence; ignored in ADD/SUB.
REQ-011 SHALL have port a, input, LANES*N bits: lane i operand at bits [i*N +: N].
REQ-012 SHALL have port b, input, LANES*N bits: lane i second operand; ignored in ACC.
REQ-013 SHALL have port out_valid, output, 1 bit: result valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts; result transfers when out_valid && out_ready.
REQ-015 SHALL have port c, output, LANES*N bits: registered per-lane result.
REQ-016 SHALL have port ovf, output, LANES bits: per-lane overflow flag, qualified by out_valid.

Function
REQ-017 SHALL compute each lane at N+1 bits (sign-extended operands) and detect overflow when the N+1-bit result exceeds the range [-2^(N-1), 2^(N-1)-1].
REQ-018 SHALL, on overflow with SAT=1, clamp to 2^(N-1)-1 (positive overflow) or -2^(N-1) (negative overflow); with SAT=0, SHALL keep the low N bits.
REQ-019 SHALL compute a+b in ADD and a-b in SUB (b negated at N+1 bits, so -(-2^(N-1)) is representable before clamping); each beat yields one result.
REQ-020 SHALL implement FSM states IDLE and ACCUM; reset state is IDLE.
REQ-021 SHALL, in IDLE, on an accepted ACC beat: load acc = a (no overflow possible); go to ACCUM if last=0; if last=1, emit acc and stay in IDLE.
REQ-022 SHALL, in ACCUM, treat every accepted beat as ACC regardless of mode: acc = sat/wrap(acc + a), applied per step.
REQ-023 SHALL, in ACCUM, on an accepted beat with last=1, emit the updated acc, clear acc to 0 and return to IDLE.
REQ-024 SHALL make the ovf flag per lane sticky across an ACC sequence and clear it when the sequence ends.
REQ-025 SHALL register c/ovf/out_valid exactly 1 cycle after the accepted producing beat; non-last ACC beats produce no output.
REQ-026 SHALL drive in_ready = !rst && (!out_valid || out_ready), using a single output register; a new result and a drain in the same cycle is legal (full throughput, one beat per cycle).
REQ-027 SHALL hold c and ovf stable while out_valid && !out_ready.
REQ-028 SHALL ignore a, b, mode and last when no transfer occurs, leaving the FSM and acc unchanged.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set state=IDLE, acc=0, c=0, ovf=0, out_valid=0; in_ready SHALL be 0 while rst is high.
REQ-030 SHALL make reset abort any in-progress ACC sequence and discard any pending output without emitting it.

Verification (N=8, Q=4, LANES=4)
REQ-031 SHALL verify ADD with SAT=1 and lane0 a=0x18, b=0x10 -> next cycle c lane0=0x28, ovf[0]=0, out_valid=1.
REQ-032 SHALL verify ADD with lane0 a=0x70, b=0x20 -> SAT=1 gives 0x7F, ovf[0]=1; SAT=0 gives 0x90, ovf[0]=1.
REQ-033 SHALL verify SUB with lane0 a=0x80, b=0x01 -> 0x80, ovf[0]=1; SUB with a=0x00, b=0x80 -> 0x7F, ovf[0]=1 (SAT=1).
REQ-034 SHALL verify ACC with 4 beats, lane0 a=0x10, last on beat 4 -> exactly one output, 0x40, ovf=0; then a 1-beat ACC (a=0x05, last=1) -> 0x05, proving acc cleared.
REQ-035 SHALL verify backpressure: out_ready=0 for 3 cycles with a result pending -> c constant, in_ready=0, no beat lost; out_ready=1 -> drain and accept in the same cycle.
REQ-036 SHALL verify rst pulse after 2 ACC beats -> out_valid=0, no output; new ACC a=0x03, last=1 -> c=0x03.
